ruta_datos_mult: RTL and testbench

RUTA_DATOS_MULT -- requirements
Module: ruta_datos_mult

---
 rtl/mult_defs_pkg.sv | 17 +
 rtl/ruta_datos_mult_sumador.sv | 20 ++
 rtl/ruta_datos_mult.sv | 134 +++++++++++++
 tb/tb_ruta_datos_mult.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_defs_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and the bit positions of the control word driven by the control unit.
package mult_defs;

  localparam int unsigned N_DEFAULT = 4;

  // Control word layout, shared with the control unit
  localparam int unsigned CTRL_W          = 5;
  localparam int unsigned CTRL_CARGA_Q    = 0;
  localparam int unsigned CTRL_DESPLAZA_Q = 1;
  localparam int unsigned CTRL_RESET_A    = 2;
  localparam int unsigned CTRL_CARGA_A    = 3;
  localparam int unsigned CTRL_FIN        = 4;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/ruta_datos_mult_sumador.sv
// sumador: (N+1)-bit unsigned adder for the multiplier accumulator.
// Ports:
//   a     - accumulator operand (N bits)
//   m     - multiplicand operand (N bits)
//   sum   - low N bits of a + m
//   carry - carry out of a + m
module sumador
  import mult_defs::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  output logic [N-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = (N+1)'(a) + (N+1)'(m);

endmodule

// File: rtl/ruta_datos_mult.sv
// ruta_datos_mult: datapath of an unsigned shift-and-add multiplier.
// Holds M (multiplicand), Q (multiplier / low product), A (accumulator) and
// carry C. The control unit sequences CargaQ/ResetA/CargaA/DesplazaQ/Fin; any
// combination of controls is legal.
// Optional feature: define DP_PRODUCT_REG_EN to register the product on Fin
// (valid then holds until the next CargaQ or reset). Without it, producto is
// {A,Q} and valid is Fin, both combinational.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   CargaQ         - load Q <= multiplicador, M <= multiplicando
//   DesplazaQ      - shift {C,A,Q} right by one
//   ResetA         - clear A and C (wins over CargaA)
//   CargaA         - {C,A} <= A + M
//   Fin            - publish product
//   multiplicando  - multiplicand operand
//   multiplicador  - multiplier operand
//   q0             - Q[0] for the control unit
//   producto       - 2N-bit product
//   valid          - producto holds a finished result
module ruta_datos_mult
  import mult_defs::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CargaQ,
  input  logic           DesplazaQ,
  input  logic           ResetA,
  input  logic           CargaA,
  input  logic           Fin,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           q0,
  output logic [2*N-1:0] producto,
  output logic           valid
);

  localparam int unsigned PW = 2 * N;

  ctrl_t        ctrl;
  logic [N-1:0] m_q, q_q, a_q;
  logic         c_q;
  logic [N-1:0] m_nxt, q_nxt, a_nxt;
  logic         c_nxt;
  logic [N-1:0] a_pre;
  logic         c_pre;
  logic [N-1:0] sum;
  logic         carry;

  assign ctrl = {Fin, CargaA, ResetA, DesplazaQ, CargaQ};

  sumador #(.N(N)) u_sumador (
    .a     (a_q),
    .m     (m_q),
    .sum   (sum),
    .carry (carry)
  );

  // Next-state: accumulator update first, then optional shift of the result
  always_comb begin
    a_pre = a_q;
    c_pre = c_q;
    a_nxt = a_q;
    c_nxt = c_q;
    q_nxt = q_q;
    m_nxt = m_q;

    if (ctrl[CTRL_RESET_A]) begin
      a_pre = '0;
      c_pre = 1'b0;
    end else if (ctrl[CTRL_CARGA_A]) begin
      a_pre = sum;
      c_pre = carry;
    end

    a_nxt = a_pre;
    c_nxt = c_pre;

    if (ctrl[CTRL_DESPLAZA_Q]) begin
      c_nxt = 1'b0;
      a_nxt = {c_pre, a_pre[N-1:1]};
      q_nxt = {a_pre[0], q_q[N-1:1]};
    end

    // Operand load overrides the shift for Q only
    if (ctrl[CTRL_CARGA_Q]) begin
      q_nxt = multiplicador;
      m_nxt = multiplicando;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      q_q <= '0;
      a_q <= '0;
      c_q <= 1'b0;
    end else begin
      m_q <= m_nxt;
      q_q <= q_nxt;
      a_q <= a_nxt;
      c_q <= c_nxt;
    end
  end

  assign q0 = q_q[0];

`ifdef DP_PRODUCT_REG_EN
  logic [PW-1:0] prod_q;
  logic          valid_q;

  // Product capture on Fin; a new operand load retires the old result
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (ctrl[CTRL_FIN]) begin
      prod_q  <= {a_q, q_q};
      valid_q <= 1'b1;
    end else if (ctrl[CTRL_CARGA_Q]) begin
      valid_q <= 1'b0;
    end
  end

  assign producto = prod_q;
  assign valid    = valid_q;
`else
  assign producto = PW'({a_q, q_q});
  assign valid    = ctrl[CTRL_FIN];
`endif

endmodule

// File: tb/tb_ruta_datos_mult.sv
// Testbench for ruta_datos_mult (N=4). Works with DP_PRODUCT_REG_EN either
// defined or undefined; the reference model follows the same setting.
module tb_ruta_datos_mult;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned MASK = (1 << N) - 1;

`ifdef DP_PRODUCT_REG_EN
  localparam bit PROD_REG = 1'b1;
`else
  localparam bit PROD_REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, CargaQ, DesplazaQ, ResetA, CargaA, Fin;
  logic [N-1:0]  multiplicando, multiplicador;
  logic          q0;
  logic [PW-1:0] producto;
  logic          valid;

  always #5 clk = ~clk;

  ruta_datos_mult #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .CargaQ        (CargaQ),
    .DesplazaQ     (DesplazaQ),
    .ResetA        (ResetA),
    .CargaA        (CargaA),
    .Fin           (Fin),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .q0            (q0),
    .producto      (producto),
    .valid         (valid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: registers as plain integers
  int unsigned mm = 0, mq = 0, ma = 0, mc = 0, mprod = 0;
  bit          mvalid = 1'b0;

  function automatic int unsigned exp_prod();
    return PROD_REG ? mprod : ((ma << N) | mq);
  endfunction

  function automatic bit exp_valid();
    return PROD_REG ? mvalid : Fin;
  endfunction

  // Drive one cycle of controls and advance the model past the rising edge
  task automatic apply(input bit rst, input bit cq, input bit dq, input bit ra,
                       input bit ca, input bit fin,
                       input int unsigned mcand, input int unsigned mplier);
    int unsigned old_aq, na, nc, nq, s, acq;
    @(negedge clk);
    reset = rst; CargaQ = cq; DesplazaQ = dq; ResetA = ra; CargaA = ca; Fin = fin;
    multiplicando = N'(mcand);
    multiplicador = N'(mplier);
    @(posedge clk);
    old_aq = (ma << N) | mq;
    if (rst) begin
      mm = 0; mq = 0; ma = 0; mc = 0; mprod = 0; mvalid = 1'b0;
    end else begin
      na = ma; nc = mc;
      if (ra) begin
        na = 0; nc = 0;
      end else if (ca) begin
        s  = ma + mm;
        na = s & MASK;
        nc = s >> N;
      end
      nq = mq;
      if (dq) begin
        acq = (nc << (2 * N)) + (na << N) + mq;
        acq = acq / 2;
        nc  = 0;
        na  = (acq >> N) & MASK;
        nq  = acq & MASK;
      end
      if (cq) begin
        nq = mplier & MASK;
        mm = mcand & MASK;
      end
      if (fin) begin
        mprod  = old_aq;
        mvalid = 1'b1;
      end else if (cq) begin
        mvalid = 1'b0;
      end
      ma = na; mc = nc; mq = nq;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 1, 1, $urandom_range(0, 15), $urandom_range(0, 15));
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (producto !== PW'(0)) begin
      miscompares++;
      $display("FAIL reset_producto got %0d expected 0", producto);
    end
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %0b expected 0", valid);
    end
    vectors++;
    if (q0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_q0 got %0b expected 0", q0);
    end
  endtask

  // Full shift-and-add sequence, checked every cycle and against a*b
  task automatic test_mult(input string name, input int unsigned a, input int unsigned b);
    apply(0, 1, 0, 1, 0, 0, a, b);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (q0 !== 1'(mq & 1)) begin
        miscompares++;
        $display("FAIL %s_q0 it%0d got %0b expected %0b", name, i, q0, mq & 1);
      end
      apply(0, 0, 1, 0, 1'(mq & 1), 0, a, b);
      vectors++;
      if (producto !== PW'(exp_prod())) begin
        miscompares++;
        $display("FAIL %s_track it%0d got %0d expected %0d", name, i, producto, exp_prod());
      end
    end
    apply(0, 0, 0, 0, 0, 1, a, b);
    vectors++;
    if (producto !== PW'(a * b)) begin
      miscompares++;
      $display("FAIL %s_product got %0d expected %0d", name, producto, a * b);
    end
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid got %0b expected 1", name, valid);
    end
    apply(0, 0, 0, 0, 0, 0, a, b);
    vectors++;
    if (valid !== exp_valid() || producto !== PW'(a * b)) begin
      miscompares++;
      $display("FAIL %s_after got valid=%0b prod=%0d expected valid=%0b prod=%0d",
               name, valid, producto, exp_valid(), a * b);
    end
  endtask

  task automatic test_reset_a_priority();
    apply(0, 1, 0, 1, 0, 0, 5, 0);     // M=5, Q=0, A=0
    apply(0, 0, 0, 0, 1, 0, 0, 0);     // A=5
    apply(0, 1, 0, 0, 0, 0, 3, 0);     // M=3, A stays 5
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (producto !== PW'(8'h50)) begin
      miscompares++;
      $display("FAIL rsta_setup got %0h expected 50", producto);
    end
    apply(0, 0, 0, 1, 1, 0, 0, 0);     // ResetA wins over CargaA
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (producto !== PW'(0)) begin
      miscompares++;
      $display("FAIL rsta_priority got %0h expected 0", producto);
    end
  endtask

  task automatic test_add_shift();
    apply(0, 1, 0, 1, 0, 0, 9, 6);     // A=0, M=9, Q=0110
    apply(0, 0, 1, 0, 1, 0, 9, 6);
    apply(0, 0, 0, 0, 0, 1, 9, 6);
    vectors++;
    if (producto !== PW'(8'h4B)) begin
      miscompares++;
      $display("FAIL add_shift got %0h expected 4b", producto);
    end
  endtask

  task automatic test_mid_reset();
    apply(0, 1, 0, 1, 0, 0, 13, 11);
    apply(0, 0, 1, 0, 1, 0, 13, 11);
    apply(0, 0, 0, 0, 0, 1, 13, 11);  // valid result before the abort
    apply(0, 1, 0, 1, 0, 0, 13, 11);
    apply(0, 0, 1, 0, 1, 0, 13, 11);
    apply(1, 0, 1, 0, 1, 0, 13, 11);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (producto !== PW'(0) || valid !== 1'b0 || q0 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got prod=%0d valid=%0b q0=%0b expected 0 0 0",
               producto, valid, q0);
    end
    apply(0, 0, 0, 0, 0, 1, 0, 0);
    vectors++;
    if (producto !== PW'(0) || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_fin got prod=%0d valid=%0b expected 0 1", producto, valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
      vectors++;
      if (producto !== PW'(exp_prod()) || valid !== exp_valid() || q0 !== 1'(mq & 1)) begin
        miscompares++;
        $display("FAIL random cyc%0d got prod=%0d valid=%0b q0=%0b expected prod=%0d valid=%0b q0=%0b",
                 i, producto, valid, q0, exp_prod(), exp_valid(), mq & 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned a, b;
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      apply(0, 1, 0, 1, 0, 0, a, b);
      for (int i = 0; i < N; i++) apply(0, 0, 1, 0, 1'(mq & 1), 0, a, b);
      apply(0, 0, 0, 0, 0, 1, a, b);
      vectors++;
      if (producto !== PW'(a * b) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b %0dx%0d got prod=%0d valid=%0b expected %0d 1",
                 a, b, producto, valid, a * b);
      end
    end
  endtask

  initial begin
    reset = 1'b1; CargaQ = 1'b0; DesplazaQ = 1'b0; ResetA = 1'b0; CargaA = 1'b0;
    Fin = 1'b0; multiplicando = '0; multiplicador = '0;
    test_reset();
    test_mult("m13x11", 13, 11);
    test_mult("m15x15", 15, 15);
    test_mult("m2x3", 2, 3);
    test_reset_a_priority();
    test_add_shift();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
